// File: rtl/obi_pipelined_bridge.sv
// obi_pipelined_bridge
//   Single-clock OBI register slice with pipelining. The request path is cut
//   by a one-entry slot that drives the secondary port. The response path is
//   cut by a register, or by an in-order FIFO when ctrl_rready_i exists. A
//   credit counter limits in-flight transactions to MAX_OUTSTANDING.
//
//   Optional feature macro: OBI_BRIDGE_RREADY_EN
//     Adds ctrl_rready_i and replaces the response register with a FIFO of
//     depth MAX_OUTSTANDING.
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   ctrl_req_i/gnt_o        controller request handshake (gnt is combinational)
//   ctrl_addr_i/we_i/be_i/wdata_i  controller request payload
//   ctrl_rvalid_o/rdata_o   response to the controller
//   ctrl_rready_i           response back-pressure (OBI_BRIDGE_RREADY_EN only)
//   secondary_req_o/gnt_i   registered request handshake to the peripheral
//   secondary_addr_o/we_o/be_o/wdata_o  registered request payload
//   secondary_rvalid_i/rdata_i  peripheral response
//   outstanding_o           current credit count
module obi_pipelined_bridge #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_W           = DATA_W / 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ctrl_req_i,
    output logic              ctrl_gnt_o,
    input  logic [ADDR_W-1:0] ctrl_addr_i,
    input  logic              ctrl_we_i,
    input  logic [BE_W-1:0]   ctrl_be_i,
    input  logic [DATA_W-1:0] ctrl_wdata_i,
    output logic              ctrl_rvalid_o,
    output logic [DATA_W-1:0] ctrl_rdata_o,
`ifdef OBI_BRIDGE_RREADY_EN
    input  logic              ctrl_rready_i,
`endif
    output logic              secondary_req_o,
    input  logic              secondary_gnt_i,
    output logic [ADDR_W-1:0] secondary_addr_o,
    output logic              secondary_we_o,
    output logic [BE_W-1:0]   secondary_be_o,
    output logic [DATA_W-1:0] secondary_wdata_o,
    input  logic              secondary_rvalid_i,
    input  logic [DATA_W-1:0] secondary_rdata_i,
    output logic [CNT_W-1:0]  outstanding_o
);

    logic              slot_valid;
    logic [ADDR_W-1:0] slot_addr;
    logic              slot_we;
    logic [BE_W-1:0]   slot_be;
    logic [DATA_W-1:0] slot_wdata;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  pending;   // responses captured but not yet delivered
    logic              accept;    // secondary response is taken into the bridge
    logic              deliver;   // response handed to the controller this cycle

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    // The slot may be refilled in the same cycle its current content is
    // granted downstream, giving one request per cycle.
    assign ctrl_gnt_o = rst_ni && ctrl_req_i
                      && (cnt < CNT_W'(MAX_OUTSTANDING))
                      && (!slot_valid || secondary_gnt_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_we    <= 1'b0;
            slot_be    <= '0;
            slot_wdata <= '0;
        end else if (ctrl_gnt_o) begin
            slot_valid <= 1'b1;
            slot_addr  <= ctrl_addr_i;
            slot_we    <= ctrl_we_i;
            slot_be    <= ctrl_be_i;
            slot_wdata <= ctrl_wdata_i;
        end else if (slot_valid && secondary_gnt_i) begin
            slot_valid <= 1'b0;
        end
    end

    assign secondary_req_o   = slot_valid;
    assign secondary_addr_o  = slot_addr;
    assign secondary_we_o    = slot_we;
    assign secondary_be_o    = slot_be;
    assign secondary_wdata_o = slot_wdata;

    // ------------------------------------------------------------------
    // Credit counter
    // ------------------------------------------------------------------
    // Credits already covered by a captured response are not available to
    // a new one; this drops responses arriving with no credit (including
    // stale ones after a reset) and keeps the counter from underflowing.
    assign accept = secondary_rvalid_i && (cnt > pending);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            case ({ctrl_gnt_o, deliver})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign outstanding_o = cnt;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
`ifdef OBI_BRIDGE_RREADY_EN
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [DATA_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  fcnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pending = fcnt;
    assign deliver = (fcnt != '0) && ctrl_rready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (accept)  wptr <= ptr_inc(wptr);
            if (deliver) rptr <= ptr_inc(rptr);
            case ({accept, deliver})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    // Storage needs no reset: the output is forced to zero while empty.
    always_ff @(posedge clk_i) begin
        if (accept) fifo_mem[wptr] <= secondary_rdata_i;
    end

    assign ctrl_rvalid_o = (fcnt != '0);
    assign ctrl_rdata_o  = (fcnt != '0) ? fifo_mem[rptr] : '0;
`else
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // The controller always accepts, so a registered response is delivered
    // in the cycle it is visible.
    assign pending = CNT_W'(rvalid_q);
    assign deliver = rvalid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= accept;
            if (accept) rdata_q <= secondary_rdata_i;
        end
    end

    assign ctrl_rvalid_o = rvalid_q;
    assign ctrl_rdata_o  = rdata_q;
`endif

endmodule
